// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: sequencer state encoding and the architectural zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    // x0 is hardwired to zero, so it can never create a data dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stall/flush controls between pipeline and controller
//
// Purpose: bundles every hazard source and every pipeline control of the controller.
// Modports:
//   master - the hazard controller: reads hazard sources, drives enables/flushes/halted/counters
//   slave  - the pipeline datapath: drives hazard sources, reads the controls
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // hazard sources
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_is_branch;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_mem_read;
    logic [4:0]       mem_rd;
    logic             flush_req;
    logic             mdu_start;
    logic             mdu_done;
    logic             imem_ready;
    logic             halt_req;
    // pipeline controls
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
               ex_mem_read, ex_rd, mem_mem_read, mem_rd,
               flush_req, mdu_start, mdu_done, imem_ready, halt_req,
        output pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
               ex_mem_read, ex_rd, mem_mem_read, mem_rd,
               flush_req, mdu_start, mdu_done, imem_ready, halt_req,
        input  pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush,
               halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle events, sticking at all-ones instead of wrapping.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset, clears the count
//   inc     - count this cycle
//   count_o - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: arbitrates load-use, ID branch redirect, multi-cycle MDU, fetch wait and
// debug halt into PC / IF-ID / ID-EX / EX-MEM enable and flush controls, and keeps
// saturating stall and redirect counters.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - pipeline_hazard_ctrl_if.master (hazard sources in, controls and counters out)
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input logic                    clk,
    input logic                    rst,
    pipeline_hazard_ctrl_if.master bus
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e          state_q, state_d;
    state_e          ret_q, ret_d;      // where MDU_WAIT resumes: RUN or DRAIN
    logic [DW-1:0]   drain_q, drain_d;

    logic pc_en, ifid_en, idex_en, exmem_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic halted;
    logic stall_inc, flush_inc;
    logic lu1, lu2, load_use;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Load in EX feeding the ID instruction: one bubble lets it reach MEM for forwarding.
    assign lu1 = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                 ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                  (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

    // Branches resolve in ID, so a load still in MEM is too late to forward: one more bubble.
    assign lu2 = bus.id_is_branch && bus.mem_mem_read && (bus.mem_rd != REG_X0) &&
                 ((bus.id_use_rs1 && (bus.mem_rd == bus.id_rs1)) ||
                  (bus.id_use_rs2 && (bus.mem_rd == bus.id_rs2)));

    assign load_use = lu1 || lu2;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_d     = drain_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.mdu_start) begin
                    // freeze IF..ID-EX, feed bubbles behind the MDU op
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    ret_d       = RUN;
                    state_d     = MDU_WAIT;
                end else if (load_use) begin
                    // redirect is ignored: its branch operands are stale this cycle
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.flush_req) begin
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (!bus.imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end else if (bus.halt_req) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    drain_d    = DRAIN_LOAD;
                    state_d    = DRAIN;
                end
            end

            MDU_WAIT: begin
                // done raised together with start is never seen here: only sampled in this state
                if (bus.mdu_done) begin
                    state_d = ret_q;
                end else begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                end
            end

            DRAIN: begin
                if (bus.mdu_start) begin
                    // drain count is held while the MDU op completes
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    ret_d       = DRAIN;
                    state_d     = MDU_WAIT;
                end else begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    if (!bus.halt_req) begin
                        state_d = RUN;
                    end else if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
            end

            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                halted   = 1'b1;
                if (!bus.halt_req) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // reset forces every register to hold a bubble, independent of state
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            halted      = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    assign stall_inc = !rst && !pc_en && (state_q != HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            drain_q <= drain_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (stall_inc),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (flush_inc),
        .count_o (flush_cnt)
    );

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.halted      = halted;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It arbitrates between competing hazard sources: load-use, branch/jump redirect from the branch-resolution logic in ID, multi-cycle MDU in EX, instruction-fetch wait, and a debug halt.
- It drives enable/flush controls for PC and the IF/ID, ID/EX and EX/MEM registers.
- It keeps saturating performance counters.

Parameters:
- CNT_W, 16, width of performance counters
- DRAIN_CYCLES, 3, bubble cycles needed to empty ID..WB before halt is acknowledged

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- id_is_branch  in  1  ID instruction is a conditional branch (resolves in ID)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_rd  in  5  MEM destination register
- flush_req  in  1  taken branch or jump resolved in ID (from flush logic)
- mdu_start  in  1  mul/div entering EX this cycle
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- imem_ready  in  1  instruction memory returns valid fetch this cycle
- halt_req  in  1  debug halt request (level)
- pc_en  out  1  PC register load enable
- ifid_en, idex_en, exmem_en  out  1  pipeline register enables
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (NOP) into the register
- halted  out  1  pipeline empty and frozen
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED
- flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- FSM states: RUN, MDU_WAIT, DRAIN, HALTED. Reset state is RUN.
- While rst=1:
  - all *_en = 0 and all *_flush = 1
  - halted = 0
  - counters = 0
  - drain counter = 0
- Outputs are combinational from state, inputs and rst.
- Hazard terms (x0 never hazards; rd=0 suppresses):
  - lu1 = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))
  - lu2 = id_is_branch & mem_mem_read & mem_rd!=0 & same rs match against mem_rd
  - load_use = lu1 | lu2. A branch that depends on a load therefore stalls 2 cycles.
- RUN, priority highest first:
  1. mdu_start: pc_en=ifid_en=idex_en=0; exmem_flush=1; flush_req ignored; next state MDU_WAIT.
  2. load_use: pc_en=ifid_en=0; idex_flush=1; flush_req ignored, because branch operands are stale.
  3. flush_req: pc_en=1 (redirect target loaded); ifid_flush=1; flush_cnt++.
  4. !imem_ready: pc_en=0; ifid_flush=1; rest advance.
  5. halt_req: pc_en=0; ifid_flush=1; drain counter=DRAIN_CYCLES-1; next state DRAIN.
  6. else: all en=1, all flush=0.
- MDU_WAIT:
  - pc_en, ifid_en and idex_en are held at 0; exmem_flush=1 each cycle.
  - mdu_done in the same cycle as mdu_start is not honoured; done is sampled only in MDU_WAIT.
  - On mdu_done: exmem_en=1, exmem_flush=0, all en=1, and the state returns to RUN. The frozen ID instruction re-evaluates next cycle.
- DRAIN:
  - pc_en=0; ifid_flush=1; idex/exmem advance.
  - The counter decrements each cycle; at 0 the next state is HALTED.
  - mdu_start in DRAIN is handled as in RUN, but the return from MDU_WAIT goes back to DRAIN with the counter preserved.
  - halt_req dropping in DRAIN returns to RUN next cycle.
- HALTED: halted=1; all en=0; all flush=0. When halt_req=0, next state is RUN.
- Counters:
  - Both counters saturate at all-ones.
  - stall_cnt increments each cycle where pc_en=0, state != HALTED and rst=0.
- Async reset mid-MDU_WAIT or mid-DRAIN aborts immediately to RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, MDU_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3)
  - REG_X0 = 5'd0
- One sub-module, sat_counter (parameter W; inputs inc, clk, rst), instantiated twice.
- Hazard detection stays inline.

Test Plan:
- Load x5 in EX, ID add reads x5 (id_use_rs1=1, id_rs1=5): exactly one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with ex_rd=0: no stall.
- Branch in ID depends on load x7: cycle1 lu1 stall; cycle2 lu2 stall (mem_rd=7). flush_req asserted during both cycles is ignored (flush_cnt=0); cycle3 flush_req gives ifid_flush=1, flush_cnt=1.
- mdu_start, then mdu_done after 4 cycles: MDU_WAIT for 4 cycles with pc_en=0, exmem_flush=1. The done cycle has exmem_en=1; RUN follows. stall_cnt=5.
- mdu_start together with flush_req in the same cycle: MDU wins, flush_cnt unchanged. Reassert flush_req after return: accepted.
- halt_req held: 3 DRAIN cycles with ifid_flush=1, then halted=1 and all en=0. Drop halt_req: RUN next cycle, pc_en=1.
- Assert rst during MDU_WAIT: outputs go immediately to reset values and counters to 0. After release: RUN, with mdu_done ignored.
